decode_h3: RTL and testbench

- Pipelined SECDED decoder for the 32-bit H3 codeword format: 26 data bits plus 6 parity bits.
- Recomputes the Hamming syndrome and overall parity, corrects any single-bit error, and flags double-bit errors.
- Sits on the read path of the ECC datapath, after codeword storage and in front of the consumer.
- Uses a valid/ready handshake on both sides, with optional saturating error statistics.

---
 rtl/decode_h3.sv | 172 +++++++++++++++++
 tb/tb_decode_h3.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_h3.sv
// decode_h3: two-stage SECDED decoder for the 32-bit H3 codeword
// {data[25:0], parity[5:0]}.
// Stage 1 registers the accepted codeword. Stage 2 registers the decoded
// result, which is either corrected or flagged.
// The optional saturating error counters are enabled by defining
// DECODE_H3_ERR_CNT_EN. When it is not defined, SE_CNT and DE_CNT are tied
// to zero.
module decode_h3 #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] CodeWord,
  input  logic                  VALID_IN,
  output logic                  READY_IN,
  output logic [25:0]           DATA_OUT,
  output logic [1:0]            ERR_STATUS,
  output logic [5:0]            SYNDROME,
  output logic                  VALID_OUT,
  input  logic                  READY_OUT,
  input  logic                  CNT_CLR,
  output logic [CNT_WIDTH-1:0]  SE_CNT,
  output logic [CNT_WIDTH-1:0]  DE_CNT
);

  // Data-bit coverage of each Hamming parity bit. Data bit j sits at the
  // j-th non-power-of-two position (3, 5, 6, 7, 9, ...), and parity bit k
  // covers every position whose index has bit k set.
  localparam logic [25:0] P0_MASK = 26'h2AAAD5B;
  localparam logic [25:0] P1_MASK = 26'h333366D;
  localparam logic [25:0] P2_MASK = 26'h3C3C78E;
  localparam logic [25:0] P3_MASK = 26'h3FC07F0;
  localparam logic [25:0] P4_MASK = 26'h3FFF800;

  // Returns the Hamming position of data bit j.
  function automatic logic [4:0] pos_of(input int j);
    int          n;
    logic [4:0]  r;
    n = 0;
    r = '0;
    for (int p = 3; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == j) r = 5'(p);
        n++;
      end
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] s1_cw;
  logic                  s1_valid;
  logic                  s2_adv;

  logic [25:0] rx_data;
  logic [5:0]  rx_par;
  logic [4:0]  p_calc;
  logic [4:0]  synd;
  logic        overall;
  logic        synd_pow2;
  logic [25:0] flip;
  logic [25:0] dec_data;
  logic [1:0]  dec_err;

  logic [25:0] out_data;
  logic [1:0]  out_err;
  logic [5:0]  out_syn;
  logic        out_valid;

  // Stage 2 moves whenever it is empty or its output is being taken.
  // Stage 1 can accept whenever it is empty or is moving into stage 2.
  assign s2_adv   = !out_valid || READY_OUT;
  assign READY_IN = !s1_valid || s2_adv;

  // Stage 1 capture register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (READY_IN) begin
      s1_valid <= VALID_IN;
      if (VALID_IN) s1_cw <= CodeWord;
    end
  end

  assign rx_data = s1_cw[31:6];
  assign rx_par  = s1_cw[5:0];

  // Recompute the syndrome and overall parity from the stage-1 codeword.
  always_comb begin
    p_calc[0] = ^(rx_data & P0_MASK);
    p_calc[1] = ^(rx_data & P1_MASK);
    p_calc[2] = ^(rx_data & P2_MASK);
    p_calc[3] = ^(rx_data & P3_MASK);
    p_calc[4] = ^(rx_data & P4_MASK);
    synd      = p_calc ^ rx_par[4:0];
    overall   = ^s1_cw;
    synd_pow2 = (synd & (synd - 5'd1)) == 5'd0;
  end

  // Build a one-hot mask of the data bit addressed by the syndrome. It is
  // all-zero when the syndrome points at a parity bit or is zero.
  always_comb begin
    flip = '0;
    for (int j = 0; j < 26; j++) begin
      flip[j] = (synd == pos_of(j));
    end
  end

  // Classify the error and correct single-bit data errors.
  // A double error leaves the data untouched.
  always_comb begin
    dec_data = rx_data;
    dec_err  = 2'b00;
    if (overall) begin
      dec_err = 2'b01;
      if (!synd_pow2) dec_data = rx_data ^ flip;
    end else if (synd != 5'd0) begin
      dec_err = 2'b10;
    end
  end

  // Stage 2 output register. It holds steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= '0;
      out_syn   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= dec_data;
        out_err  <= dec_err;
        out_syn  <= {overall, synd};
      end
    end
  end

  assign VALID_OUT  = out_valid;
  assign DATA_OUT   = out_data;
  assign ERR_STATUS = out_err;
  assign SYNDROME   = out_syn;

`ifdef DECODE_H3_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] se_q;
  logic [CNT_WIDTH-1:0] de_q;
  logic                 out_hs;

  assign out_hs = out_valid && READY_OUT;

  // Saturating error counters. A clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst || CNT_CLR) begin
      se_q <= '0;
      de_q <= '0;
    end else if (out_hs) begin
      if (out_err == 2'b01 && se_q != '1) se_q <= se_q + 1'b1;
      if (out_err == 2'b10 && de_q != '1) de_q <= de_q + 1'b1;
    end
  end

  assign SE_CNT = se_q;
  assign DE_CNT = de_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = CNT_CLR;
  assign SE_CNT = '0;
  assign DE_CNT = '0;
`endif

endmodule

// File: tb/tb_decode_h3.sv
// tb_decode_h3: scoreboard bench for decode_h3. The expected result of every
// accepted codeword is queued on the input handshake and is checked against
// the output whenever VALID_OUT is high.
module tb_decode_h3;

  localparam int CNTW = 4;
  localparam int SAT  = (1 << CNTW) - 1;

  typedef struct packed {
    logic [25:0] d;
    logic [1:0]  e;
    logic [5:0]  s;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     CodeWord;
  logic            VALID_IN;
  logic            READY_IN;
  logic [25:0]     DATA_OUT;
  logic [1:0]      ERR_STATUS;
  logic [5:0]      SYNDROME;
  logic            VALID_OUT;
  logic            READY_OUT;
  logic            CNT_CLR;
  logic [CNTW-1:0] SE_CNT;
  logic [CNTW-1:0] DE_CNT;

  exp_t sb[$];
  exp_t mon_e;
  int   total  = 0;
  int   bad    = 0;
  int   exp_se = 0;
  int   exp_de = 0;

  decode_h3 #(.DATA_WIDTH(32), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .CodeWord(CodeWord), .VALID_IN(VALID_IN),
    .READY_IN(READY_IN), .DATA_OUT(DATA_OUT), .ERR_STATUS(ERR_STATUS),
    .SYNDROME(SYNDROME), .VALID_OUT(VALID_OUT), .READY_OUT(READY_OUT),
    .CNT_CLR(CNT_CLR), .SE_CNT(SE_CNT), .DE_CNT(DE_CNT)
  );

  // Free-running clock.
  initial forever #5 clk = ~clk;

  // Encode data into a clean H3 codeword by walking the Hamming positions.
  function automatic logic [31:0] enc(input logic [25:0] d);
    logic [4:0] s;
    logic [5:0] par;
    int         j;
    s = '0;
    j = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[j]) s = s ^ 5'(p);
        j++;
      end
    end
    par[4:0] = s;
    par[5]   = ^{d, s};
    return {d, par};
  endfunction

  // Reference decoder: syndrome as the XOR of the positions of all set bits.
  function automatic exp_t model(input logic [31:0] cw);
    exp_t       r;
    logic [4:0] s;
    logic       ov;
    logic       b;
    int         j, k, np, rk;
    s = '0;
    j = 0;
    k = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) == 0) begin
        b = cw[k];
        k++;
      end else begin
        b = cw[6 + j];
        j++;
      end
      if (b) s = s ^ 5'(p);
    end
    ov  = ^cw;
    r.d = cw[31:6];
    r.s = {ov, s};
    if (ov) begin
      r.e = 2'b01;
      if ((s & (s - 5'd1)) != 5'd0) begin
        np = 0;
        for (int q = 0; q < 5; q++) if ((1 << q) <= int'(s)) np++;
        rk = int'(s) - np - 1;
        r.d[rk] = ~r.d[rk];
      end
    end else if (s != 5'd0) begin
      r.e = 2'b10;
    end else begin
      r.e = 2'b00;
    end
    return r;
  endfunction

  // Random encoded word with 0, 1 or 2 flipped bits.
  function automatic logic [31:0] rand_word(input int nerr);
    logic [31:0] w;
    int          b1, b2;
    w  = enc(26'($urandom));
    b1 = $urandom_range(0, 31);
    b2 = (b1 + $urandom_range(1, 31)) % 32;
    if (nerr >= 1) w[b1] = ~w[b1];
    if (nerr >= 2) w[b2] = ~w[b2];
    return w;
  endfunction

  // Scoreboard monitor. It samples at the falling edge, midway between
  // active edges.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      exp_se = 0;
      exp_de = 0;
    end else begin
      if (VALID_OUT) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: VALID_OUT=1 data=%h but nothing outstanding", DATA_OUT);
        end else begin
          mon_e = sb[0];
          if ({DATA_OUT, ERR_STATUS, SYNDROME} !== mon_e) begin
            bad++;
            $display("FAIL sb_output: got data=%h err=%b syn=%h, want data=%h err=%b syn=%h",
                     DATA_OUT, ERR_STATUS, SYNDROME, mon_e.d, mon_e.e, mon_e.s);
          end
          if (READY_OUT) begin
`ifdef DECODE_H3_ERR_CNT_EN
            if (mon_e.e == 2'b01 && exp_se < SAT) exp_se++;
            if (mon_e.e == 2'b10 && exp_de < SAT) exp_de++;
`endif
            void'(sb.pop_front());
          end
        end
      end
`ifdef DECODE_H3_ERR_CNT_EN
      if (CNT_CLR) begin
        exp_se = 0;
        exp_de = 0;
      end
`endif
      if (VALID_IN && READY_IN) sb.push_back(model(CodeWord));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; VALID_IN = 1'b0; READY_OUT = 1'b1; CNT_CLR = 1'b0; CodeWord = '0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    total++;
    if ({VALID_OUT, DATA_OUT, ERR_STATUS, SYNDROME} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b data=%h err=%b syn=%h, want all zero",
               VALID_OUT, DATA_OUT, ERR_STATUS, SYNDROME);
    end
    total++;
    if (READY_IN !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_in: got %b want 1", READY_IN);
    end
    total++;
    if (SE_CNT !== '0 || DE_CNT !== '0) begin
      bad++;
      $display("FAIL reset_counters: got se=%0d de=%0d want 0 0", SE_CNT, DE_CNT);
    end
  endtask

  task automatic test_known_vectors();
    logic [31:0] kcw [4];
    logic [33:0] kexp [4];
    kcw[0] = 32'h00000063; kexp[0] = {26'h1, 2'b00, 6'h00};
    kcw[1] = 32'h00000023; kexp[1] = {26'h1, 2'b01, 6'h23};
    kcw[2] = 32'h00000043; kexp[2] = {26'h1, 2'b01, 6'h20};
    kcw[3] = 32'h00000060; kexp[3] = {26'h1, 2'b10, 6'h03};
    for (int i = 0; i < 4; i++) begin
      CodeWord = kcw[i]; VALID_IN = 1'b1; READY_OUT = 1'b1;
      cyc();
      VALID_IN = 1'b0;
      cyc();
      total++;
      if (VALID_OUT !== 1'b1 || {DATA_OUT, ERR_STATUS, SYNDROME} !== kexp[i]) begin
        bad++;
        $display("FAIL known_vec%0d: got valid=%b data=%h err=%b syn=%h, want valid=1 {data,err,syn}=%h",
                 i, VALID_OUT, DATA_OUT, ERR_STATUS, SYNDROME, kexp[i]);
      end
      cyc();
      total++;
      if (VALID_OUT !== 1'b0 || SE_CNT !== CNTW'(exp_se) || DE_CNT !== CNTW'(exp_de)) begin
        bad++;
        $display("FAIL known_drain%0d: got valid=%b se=%0d de=%0d, want valid=0 se=%0d de=%0d",
                 i, VALID_OUT, SE_CNT, DE_CNT, exp_se, exp_de);
      end
    end
  endtask

  task automatic test_cnt_clr();
    // The counter clear lands on the same edge as a single-error handshake.
    CodeWord = 32'h00000023; VALID_IN = 1'b1; READY_OUT = 1'b1;
    cyc();
    VALID_IN = 1'b0;
    cyc();
    CNT_CLR = 1'b1;
    cyc();
    CNT_CLR = 1'b0;
    total++;
    if (SE_CNT !== '0 || DE_CNT !== '0) begin
      bad++;
      $display("FAIL cnt_clr_priority: got se=%0d de=%0d want 0 0", SE_CNT, DE_CNT);
    end
    CodeWord = 32'h00000043; VALID_IN = 1'b1;
    cyc();
    VALID_IN = 1'b0;
    cyc(); cyc();
    total++;
    if (SE_CNT !== CNTW'(exp_se) || DE_CNT !== CNTW'(exp_de)) begin
      bad++;
      $display("FAIL cnt_after_clr: got se=%0d de=%0d want %0d %0d", SE_CNT, DE_CNT, exp_se, exp_de);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    // Full-rate stream; the single errors are enough to drive SE_CNT into
    // saturation.
    READY_OUT = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      VALID_IN = (i < N);
      CodeWord = rand_word((i % 4 == 3) ? 2 : 1);
      #1;
      total++;
      if (READY_IN !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready_in: cycle %0d got %b want 1", i, READY_IN);
      end
      if (i >= 2) begin
        total++;
        if (VALID_OUT !== 1'b1) begin
          bad++;
          $display("FAIL b2b_valid_out: cycle %0d got %b want 1", i, VALID_OUT);
        end
      end
      cyc();
    end
    VALID_IN = 1'b0;
    cyc();
    total++;
    if (SE_CNT !== CNTW'(exp_se) || DE_CNT !== CNTW'(exp_de)) begin
      bad++;
      $display("FAIL b2b_counters: got se=%0d de=%0d want %0d %0d", SE_CNT, DE_CNT, exp_se, exp_de);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [4];
    exp_t        e0;
    int          idx;
    logic        acc;
    w[0] = enc(26'h0ABCDEF) ^ 32'h0000_1000;
    w[1] = enc(26'h1234567);
    w[2] = enc(26'h3FFFFFF) ^ 32'h0000_0011;
    w[3] = enc(26'h2AAAAAA) ^ 32'h8000_0000;
    e0   = model(w[0]);
    idx  = 0;
    for (int c = 1; c <= 14; c++) begin
      READY_OUT = !(c >= 3 && c <= 6);
      if (c >= 2 && idx < 4) begin
        VALID_IN = 1'b1;
        CodeWord = w[idx];
      end else begin
        VALID_IN = 1'b0;
      end
      #1;
      if (c == 3 || c == 7) begin
        total++;
        if (READY_IN !== 1'b1) begin
          bad++;
          $display("FAIL bp_ready_high: cycle %0d got %b want 1", c, READY_IN);
        end
      end
      if (c >= 4 && c <= 6) begin
        total++;
        if (READY_IN !== 1'b0) begin
          bad++;
          $display("FAIL bp_ready_low: cycle %0d got %b want 0", c, READY_IN);
        end
      end
      if (c >= 4 && c <= 7) begin
        total++;
        if (VALID_OUT !== 1'b1 || {DATA_OUT, ERR_STATUS, SYNDROME} !== e0) begin
          bad++;
          $display("FAIL bp_hold: cycle %0d got valid=%b data=%h err=%b syn=%h, want data=%h err=%b syn=%h",
                   c, VALID_OUT, DATA_OUT, ERR_STATUS, SYNDROME, e0.d, e0.e, e0.s);
        end
      end
      acc = VALID_IN && READY_IN;
      cyc();
      if (acc) idx++;
    end
    VALID_IN = 1'b0;
    total++;
    if (idx != 4 || sb.size() != 0) begin
      bad++;
      $display("FAIL bp_all_words: accepted=%0d outstanding=%0d, want 4 and 0", idx, sb.size());
    end
  endtask

  task automatic test_random_stream();
    logic pend;
    pend = 1'b0;
    for (int c = 0; c < 300; c++) begin
      READY_OUT = ($urandom_range(0, 9) < 7);
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend     = 1'b1;
        CodeWord = rand_word($urandom_range(0, 2));
      end
      VALID_IN = pend;
      #1;
      if (VALID_IN && READY_IN) pend = 1'b0;
      cyc();
    end
    VALID_IN = 1'b0;
    READY_OUT = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) cyc();
    cyc();
    total++;
    if (sb.size() != 0 || SE_CNT !== CNTW'(exp_se) || DE_CNT !== CNTW'(exp_de)) begin
      bad++;
      $display("FAIL rand_drain: outstanding=%0d se=%0d de=%0d, want 0 %0d %0d",
               sb.size(), SE_CNT, DE_CNT, exp_se, exp_de);
    end
  endtask

  task automatic test_reset_mid();
    READY_OUT = 1'b0;
    VALID_IN  = 1'b1; CodeWord = enc(26'h0000F0F) ^ 32'h0000_0400;
    cyc();
    CodeWord = enc(26'h1111111) ^ 32'h0000_0003;
    cyc();
    CodeWord = enc(26'h2222222);
    #1;
    total++;
    if (VALID_OUT !== 1'b1 || READY_IN !== 1'b0) begin
      bad++;
      $display("FAIL mid_full: got valid_out=%b ready_in=%b, want 1 0", VALID_OUT, READY_IN);
    end
    rst = 1'b0;
    cyc();
    total++;
    if ({VALID_OUT, DATA_OUT, ERR_STATUS, SYNDROME} !== 35'd0 || SE_CNT !== '0 ||
        DE_CNT !== '0 || READY_IN !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: got valid=%b data=%h err=%b syn=%h se=%0d de=%0d rdy=%b, want zeros and rdy=1",
               VALID_OUT, DATA_OUT, ERR_STATUS, SYNDROME, SE_CNT, DE_CNT, READY_IN);
    end
    rst = 1'b1; VALID_IN = 1'b1; READY_OUT = 1'b1; CodeWord = 32'h00000063;
    cyc();
    VALID_IN = 1'b0;
    cyc();
    total++;
    if (VALID_OUT !== 1'b1 || {DATA_OUT, ERR_STATUS, SYNDROME} !== {26'h1, 2'b00, 6'h00}) begin
      bad++;
      $display("FAIL mid_after: got valid=%b data=%h err=%b syn=%h, want 1 0000001 00 00",
               VALID_OUT, DATA_OUT, ERR_STATUS, SYNDROME);
    end
    cyc(); cyc();
    total++;
    if (VALID_OUT !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL mid_drain: got valid=%b outstanding=%0d, want 0 0", VALID_OUT, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_cnt_clr();
    test_back_to_back();
    test_backpressure();
    test_random_stream();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
